vector_core_scheduler: RTL
==========================

# vector_core_scheduler

Job dispatcher for the vector cluster. The management core pushes job boot addresses over a TL-UL register port on the management peripherals crossbar. The block queues them and dispatches each to an idle vector core by holding the core in reset, driving its boot address, then releasing it. It tracks per-core completion and raises an interrupt to the management core.

## Interface
- `NumCores`, default 4: number of vector cores scheduled; legal range 1..8.
- `JobFifoDepth`, default 4: job queue entries; power of two, 2..16.
- `ResetHoldCycles`, default 4: cycles a core is held in reset after its boot address is loaded; legal range 1..255.

- `clk_i`  in  1: system clock; the block has one clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `tl_i`  in  `tlul_pkg::tl_h2d_t`: register port request.
- `tl_o`  out  `tlul_pkg::tl_d2h_t`: register port response.
- `core_rst_no`  out  `NumCores`: per-core active-low reset; 0 holds the core in reset.
- `core_fetch_en_o`  out  `NumCores`: per-core instruction fetch enable.
- `core_boot_addr_o`  out  `NumCores*32`: per-core boot address; core i uses bits [32i+31:32i].
- `core_done_i`  in  `NumCores`: per-core completion pulse, one cycle wide.
- `irq_o`  out  1: level interrupt to the management core.

## Operation
- Register map, word-aligned, 32-bit accesses:
  - 0x00 JOB_PUSH, write-only: pushes wdata to the FIFO.
  - 0x04 STATUS, read-only: [7:0] busy mask, [15:8] done sticky, [20:16] FIFO count, [31] FIFO full.
  - 0x08 DONE_CLR: write-1-to-clear of done sticky [7:0].
  - 0x0C IRQ_EN: [7:0] mask.
  - 0x10 CTRL: [0] dispatch enable.
- Readback of IRQ_EN and CTRL returns the stored value.
- Bits at and above `NumCores` in the per-core fields read 0 and ignore writes.
- Error responses (`d_error`=1, rdata 0):
  - JOB_PUSH while the FIFO is full; the job is dropped.
  - Any access to an unmapped offset.
  - A read of JOB_PUSH.
- `irq_o` = |(done_sticky & irq_en).
- Per-core FSM:
  - IDLE: rst_no=0, fetch_en=0.
  - IDLE -> LOAD when the dispatcher selects the core. The boot address is latched from the FIFO head and the hold counter is loaded with `ResetHoldCycles`.
  - LOAD: rst_no=0. The counter decrements each cycle; LOAD -> RUN when it reaches 0.
  - RUN: rst_no=1, fetch_en=1.
  - RUN -> IDLE on `core_done_i`; this sets the core's done sticky bit.
- `core_done_i` outside RUN is ignored.
- Dispatcher:
  - At most one pop per cycle, when CTRL[0]=1, the FIFO is non-empty and at least one core is IDLE.
  - Core selection is round-robin: the first IDLE core at or after the pointer, with wrap-around.
  - The pointer advances to (selected+1) mod `NumCores`.
- Clearing CTRL[0] stops new dispatches only. Cores in LOAD or RUN continue; queued jobs are retained.
- Simultaneous events:
  - Done and DONE_CLR on the same bit in the same cycle: set wins.
  - Push and pop in the same cycle: full is judged on the pre-cycle count, so a push at full is rejected even if a pop occurs.
- The boot address output holds its last value after return to IDLE.

## Timing
- Reset values:
  - `core_rst_no`=0, `core_fetch_en_o`=0, `core_boot_addr_o`=0, `irq_o`=0.
  - `tl_o.d_valid`=0, `tl_o.a_ready`=1.
  - FIFO empty, all registers 0, RR pointer 0.
- TL-UL handshake:
  - One outstanding transaction. `a_ready` = !response_pending.
  - A request accepted at cycle t produces `d_valid` at t+1. `d_valid` and response fields are held stable until `d_ready`.
  - `a_ready` returns high the cycle after the `d_valid`&`d_ready` handshake.
  - Get returns AccessAckData; Put returns AccessAck. `d_source` and `d_size` echo the request.
- JOB_PUSH accepted at t: FIFO count is visible at t+1; earliest dispatch decision at t+1; core enters LOAD at t+2.
- With `ResetHoldCycles`=N, `core_rst_no` and `core_fetch_en_o` rise N cycles after LOAD entry, both in the same cycle.
- `core_done_i` at t: at t+1 `core_rst_no`=0, `core_fetch_en_o`=0, the done sticky bit is set and `irq_o` is updated. The core can be re-dispatched at t+1, entering LOAD at t+2.
- Register writes take effect the cycle after `a` acceptance.
- Asserting `rst_ni` mid-operation returns all state to reset values immediately; the FIFO is flushed.

## Test plan
- Reset release, then read STATUS -> 0x00000000; all `core_rst_no`=0; `irq_o`=0.
- CTRL=1, push 0x8000_0000 -> core0 `boot_addr`=0x8000_0000. `core_rst_no[0]` rises exactly 4 cycles after LOAD entry; STATUS busy mask=0x01.
- CTRL=0, push 5 jobs with depth 4 -> the 5th response has `d_error`=1; STATUS count=4, full=1. Then CTRL=1 -> cores 0,1,2,3 are dispatched on consecutive cycles and count=0.
- IRQ_EN=0x02; pulse `core_done_i[1]` -> done sticky=0x02 and `irq_o`=1 at t+1. Core1 re-dispatches from a queued job. Write DONE_CLR=0x02 in the same cycle as another done[1] -> the bit remains 1.
- Round-robin: all cores busy, 2 queued jobs; done[2] then done[0] -> the jobs go to core2, then core0. Pointer check: the next single idle selection follows core0+1.
- Read 0x40 -> `d_error`=1, rdata 0. Hold `d_ready`=0 for 3 cycles -> `d_valid` and data are stable, and `a_ready`=0 throughout.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL request/response types for the register port.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/vector_core_scheduler.sv
// Job dispatcher: queues boot addresses written over TL-UL and launches them on idle
// vector cores (reset hold, boot address, release), tracking completion with an interrupt.
module vector_core_scheduler
    import tlul_pkg::*;
#(
    parameter int unsigned NumCores        = 4,
    parameter int unsigned JobFifoDepth    = 4,
    parameter int unsigned ResetHoldCycles = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  tl_h2d_t                  tl_i,
    output tl_d2h_t                  tl_o,
    output logic [NumCores-1:0]      core_rst_no,
    output logic [NumCores-1:0]      core_fetch_en_o,
    output logic [NumCores*32-1:0]   core_boot_addr_o,
    input  logic [NumCores-1:0]      core_done_i,
    output logic                     irq_o
);

    localparam int unsigned PtrW  = (NumCores > 1) ? $clog2(NumCores) : 1;
    localparam int unsigned AddrW = $clog2(JobFifoDepth);
    localparam int unsigned CntW  = AddrW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} core_state_e;

    // Register port
    logic        rsp_pending_q, rsp_error_q, rsp_error_d;
    tl_d_op_e    rsp_opcode_q;
    logic [1:0]  rsp_size_q;
    logic [7:0]  rsp_source_q;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic accept, is_get, is_put;
    logic push, pop;
    logic [NumCores-1:0] done_clr, irq_en_q, irq_en_d, done_q, done_d, done_set;
    logic ctrl_en_q, ctrl_en_d;
    logic [31:0] status;

    // Job FIFO
    logic [31:0]      fifo_mem [JobFifoDepth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             fifo_full, fifo_empty;

    // Cores and dispatcher
    core_state_e         state_q [NumCores];
    core_state_e         state_d [NumCores];
    logic [7:0]          hold_q  [NumCores];
    logic [7:0]          hold_d  [NumCores];
    logic [31:0]         boot_q  [NumCores];
    logic [31:0]         boot_d  [NumCores];
    logic [NumCores-1:0] idle, busy;
    logic [PtrW-1:0]     rr_q, rr_d, sel, rr_idx_p;
    int unsigned         rr_idx;
    logic                found;

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[31:12],
                         tl_i.a_address[1:0]};

    assign accept     = tl_i.a_valid & ~rsp_pending_q;
    assign is_get     = (tl_i.a_opcode == Get);
    assign is_put     = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
    assign fifo_full  = (count_q == CntW'(JobFifoDepth));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        status                = '0;
        status[NumCores-1:0]  = busy;
        status[8 +: NumCores] = done_q;
        status[20:16]         = 5'(count_q);
        status[31]            = fifo_full;
    end

    always_comb begin
        rsp_data_d  = '0;
        rsp_error_d = 1'b0;
        push        = 1'b0;
        done_clr    = '0;
        irq_en_d    = irq_en_q;
        ctrl_en_d   = ctrl_en_q;
        if (accept) begin
            if (!is_get && !is_put) begin
                rsp_error_d = 1'b1;
            end else begin
                unique case (tl_i.a_address[11:0])
                    12'h000: begin
                        // Full is judged on the pre-cycle count even if a pop happens now.
                        if (is_get || fifo_full) rsp_error_d = 1'b1;
                        else                     push        = 1'b1;
                    end
                    12'h004: if (is_get) rsp_data_d = status;
                    12'h008: if (is_put) done_clr = tl_i.a_data[NumCores-1:0];
                    12'h00C: begin
                        if (is_put) irq_en_d   = tl_i.a_data[NumCores-1:0];
                        else        rsp_data_d = 32'(irq_en_q);
                    end
                    12'h010: begin
                        if (is_put) ctrl_en_d  = tl_i.a_data[0];
                        else        rsp_data_d = {31'd0, ctrl_en_q};
                    end
                    default: rsp_error_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_pending_q <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_opcode_q  <= AccessAck;
            rsp_size_q    <= '0;
            rsp_source_q  <= '0;
            rsp_data_q    <= '0;
        end else if (accept) begin
            rsp_pending_q <= 1'b1;
            rsp_error_q   <= rsp_error_d;
            rsp_opcode_q  <= is_get ? AccessAckData : AccessAck;
            rsp_size_q    <= tl_i.a_size;
            rsp_source_q  <= tl_i.a_source;
            rsp_data_q    <= rsp_data_d;
        end else if (rsp_pending_q && tl_i.d_ready) begin
            rsp_pending_q <= 1'b0;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = rsp_pending_q;
        tl_o.d_opcode = rsp_opcode_q;
        tl_o.d_size   = rsp_size_q;
        tl_o.d_source = rsp_source_q;
        tl_o.d_data   = rsp_data_q;
        tl_o.d_error  = rsp_error_q;
        tl_o.a_ready  = ~rsp_pending_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= tl_i.a_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Round-robin: first idle core at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        rr_idx   = 0;
        rr_idx_p = '0;
        for (int k = 0; k < NumCores; k++) begin
            rr_idx = int'(rr_q) + k;
            if (rr_idx >= NumCores) rr_idx = rr_idx - NumCores;
            rr_idx_p = PtrW'(rr_idx);
            if (!found && idle[rr_idx_p]) begin
                found = 1'b1;
                sel   = rr_idx_p;
            end
        end
    end

    assign pop = ctrl_en_q & ~fifo_empty & found;

    always_comb begin
        rr_d = rr_q;
        if (pop) rr_d = (sel == PtrW'(NumCores - 1)) ? '0 : sel + 1'b1;
    end

    always_comb begin
        done_set = '0;
        for (int i = 0; i < NumCores; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            boot_d[i]  = boot_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (pop && sel == PtrW'(i)) begin
                        state_d[i] = StLoad;
                        hold_d[i]  = 8'(ResetHoldCycles);
                        boot_d[i]  = fifo_mem[rptr_q];
                    end
                end
                StLoad: begin
                    if (hold_q[i] <= 8'd1) state_d[i] = StRun;
                    else                   hold_d[i]  = hold_q[i] - 8'd1;
                end
                StRun: begin
                    if (core_done_i[i]) begin
                        state_d[i]  = StIdle;
                        done_set[i] = 1'b1;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // A completion in the same cycle as a clear keeps the bit set.
    assign done_d = (done_q & ~done_clr) | done_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCores; i++) begin
                state_q[i] <= StIdle;
                hold_q[i]  <= '0;
                boot_q[i]  <= '0;
            end
            rr_q      <= '0;
            done_q    <= '0;
            irq_en_q  <= '0;
            ctrl_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumCores; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                boot_q[i]  <= boot_d[i];
            end
            rr_q      <= rr_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            ctrl_en_q <= ctrl_en_d;
        end
    end

    always_comb begin
        idle             = '0;
        busy             = '0;
        core_rst_no      = '0;
        core_fetch_en_o  = '0;
        core_boot_addr_o = '0;
        for (int i = 0; i < NumCores; i++) begin
            idle[i]                     = (state_q[i] == StIdle);
            busy[i]                     = (state_q[i] != StIdle);
            core_rst_no[i]              = (state_q[i] == StRun);
            core_fetch_en_o[i]          = (state_q[i] == StRun);
            core_boot_addr_o[32*i +: 32] = boot_q[i];
        end
    end

    assign irq_o = |(done_q & irq_en_q);

endmodule
